hack_screen_arbiter: RTL and testbench
======================================

# hack_screen_arbiter

Shares the single-port 8K×16 Hack screen memory between the VGA scanout path (fed by `hvsync_generator` counters) and the Hack CPU data bus. Scanout reads get absolute priority. CPU writes are posted through a one-entry write buffer, and CPU reads are served in idle slots. An optional starvation guard bounds CPU latency during long scanout bursts.

## Interface
- `MAX_VGA_RUN`, default 4: consecutive VGA slots allowed while CPU work is pending. Used only with the guard enabled.
- `clk  in  1`: system clock, 25 MHz pixel-clock domain.
- `rst_n  in  1`: reset, asynchronous assert, active-low.
- `vga_req  in  1`: scanout read request for this cycle.
- `vga_addr  in  13`: scanout word address.
- `vga_gnt  out  1`: VGA read issued this cycle.
- `vga_rdata  out  16`: scanout read data.
- `vga_valid  out  1`: `vga_rdata` valid.
- `cpu_req  in  1`: CPU access request, held until `cpu_gnt`.
- `cpu_we  in  1`: 1 means write, 0 means read.
- `cpu_addr  in  13`: CPU word address.
- `cpu_wdata  in  16`: CPU write data.
- `cpu_gnt  out  1`: CPU request accepted this cycle.
- `cpu_rdata  out  16`: CPU read data.
- `cpu_rvalid  out  1`: `cpu_rdata` valid.
- `mem_en  out  1`: memory access strobe.
- `mem_we  out  1`: memory write.
- `mem_addr  out  13`: memory address.
- `mem_wdata  out  16`: memory write data.
- `mem_rdata  in  16`: memory read data, one-cycle synchronous latency.

## Operation
- **Slot:** each cycle, at most one access is issued to memory. Selection order:
  1. VGA read (`vga_req`).
  2. Write-buffer drain (`wb_valid`).
  3. CPU read (`cpu_req & ~cpu_we & ~wb_valid`).
- **Write buffer:**
  - A CPU write is accepted (`cpu_gnt=1`) iff `wb_valid=0` at cycle start.
  - On accept, `wb_addr/wb_data` are captured and `wb_valid` sets at the edge.
  - The buffer drains in a slot with `mem_we=1`.
  - Accept and drain never coincide, because accept requires the buffer empty at cycle start.
- **CPU read ordering:** a read is never issued while `wb_valid=1`. This guarantees read-after-write ordering with no forwarding.
- **Return tag:** a 2-bit registered tag records which access was issued last cycle: `NONE`, `VGA`, `CPURD` or `WB`.
  - `vga_valid = (tag==VGA)`.
  - `cpu_rvalid = (tag==CPURD)`.
  - `vga_rdata` and `cpu_rdata` are both wired to `mem_rdata`.
- **Grants and memory outputs:** `vga_gnt`, `cpu_gnt` and all `mem_*` outputs are combinational from the current-cycle decision.
- **Inactive outputs:** `mem_wdata`/`mem_addr` are 0 when `mem_en=0`.
- **Reset:**
  - Every output is 0 during reset.
  - `wb_valid=0`, tag is `NONE`, run counter is 0.
  - A buffered write pending at reset is discarded.
  - An in-flight read's return pulse is suppressed.

## Timing
- VGA read: granted in cycle t if `vga_req`, data plus `vga_valid` in t+1. Back-to-back VGA reads run at full rate.
- CPU write: `cpu_gnt` in the request cycle when the buffer is empty. Memory write occurs in the first later slot without VGA priority (or a guard-forced slot).
- CPU read: `cpu_gnt` and `mem_en` in the issue cycle, `cpu_rvalid` in the cycle after.
- `cpu_req` must hold `cpu_addr`, `cpu_we` and `cpu_wdata` stable until `cpu_gnt`. Dropping the request before grant is legal and leaves no side effect.
- `vga_req` without grant cannot occur in base configuration (VGA always wins).

## Configuration
- **`SCREEN_ARB_STARVE_GUARD_EN` defined:**
  - A run counter (width `$clog2(MAX_VGA_RUN+1)`) increments on each VGA slot taken while CPU work is pending (`wb_valid`, or a pending CPU read).
  - When the counter equals `MAX_VGA_RUN`, the next slot goes to the CPU side (drain, else read) and `vga_gnt=0` even with `vga_req=1`.
  - The counter clears on any CPU-side slot or when no CPU work is pending.
  - The VGA requester must tolerate a denied cycle, with scanout prefetch margin ≥1 word.
- **Not defined:** no counter. VGA strictly preempts, so CPU latency is unbounded during active video.

## Structure
- Shared package `hack_screen_pkg`:
  - `SCREEN_AW=13`, `WORD_W=16`.
  - Tag enum `slot_t {NONE, VGA, CPURD, WB}`.
- Sub-module `screen_wbuf`: the one-entry posted write buffer, with accept/drain handshake and `wb_valid`/`wb_addr`/`wb_data` outputs.

## Test plan
- Reset mid-activity: `rst_n` low with `wb_valid=1` and a read in flight → all outputs 0 and no `cpu_rvalid` after release. The next write is accepted immediately.
- VGA stream: `vga_req=1` for 8 cycles at addresses 0x0000–0x0007 → `vga_gnt` every cycle, `vga_valid` cycles 1–8 with memory contents in order.
- Posted write under scanout: CPU write 0x1234 → 0x0100 during VGA stream → `cpu_gnt` same cycle, memory write only on the first `vga_req=0` cycle. A second write stalls (`cpu_gnt=0`) until the drain.
- RAW ordering: write 0xBEEF → 0x0200, then immediately read 0x0200 → read waits for the drain, `cpu_rdata=0xBEEF`, `cpu_rvalid` exactly one cycle.
- Guard with macro defined and `MAX_VGA_RUN=4`: continuous `vga_req` plus pending CPU read → 4 VGA grants, 1 CPU grant, repeat. Without the macro → the CPU read is never granted.
- Idle CPU read: `vga_req=0`, read 0x1FFF → `mem_en` and `cpu_gnt` in cycle t, `cpu_rvalid` in t+1, `vga_valid` never asserted.

Source files
------------

// File: rtl/hack_screen_pkg.sv
// Shared types and sizes for the Hack screen memory arbiter.
package hack_screen_pkg;

  localparam int SCREEN_AW = 13;
  localparam int WORD_W    = 16;

  typedef logic [SCREEN_AW-1:0] addr_t;
  typedef logic [WORD_W-1:0]    word_t;

  // Which access occupied the memory port in a given cycle.
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    VGA   = 2'd1,
    CPURD = 2'd2,
    WB    = 2'd3
  } slot_t;

  function automatic logic slot_is_cpu(input slot_t s);
    return (s == CPURD) || (s == WB);
  endfunction

endpackage

// File: rtl/hack_screen_arbiter_if.sv
// Bus bundle between the scanout path, the Hack CPU, the screen RAM and the arbiter.
interface hack_screen_arbiter_if;
  import hack_screen_pkg::*;

  logic  vga_req;
  addr_t vga_addr;
  logic  vga_gnt;
  word_t vga_rdata;
  logic  vga_valid;

  logic  cpu_req;
  logic  cpu_we;
  addr_t cpu_addr;
  word_t cpu_wdata;
  logic  cpu_gnt;
  word_t cpu_rdata;
  logic  cpu_rvalid;

  logic  mem_en;
  logic  mem_we;
  addr_t mem_addr;
  word_t mem_wdata;
  word_t mem_rdata;

  modport slave (
    input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output vga_gnt, vga_rdata, vga_valid, cpu_gnt, cpu_rdata, cpu_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  vga_gnt, vga_rdata, vga_valid, cpu_gnt, cpu_rdata, cpu_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/hack_screen_arbiter_wbuf.sv
// One-entry posted write buffer: accept fills it, drain empties it.
module screen_wbuf
  import hack_screen_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  accept,
  input  addr_t accept_addr,
  input  word_t accept_data,
  input  logic  drain,
  output logic  wb_valid,
  output addr_t wb_addr,
  output word_t wb_data
);

  // Buffer state; accept only happens when empty, so it never races a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_addr  <= {SCREEN_AW{1'b0}};
      wb_data  <= {WORD_W{1'b0}};
    end else if (accept) begin
      wb_valid <= 1'b1;
      wb_addr  <= accept_addr;
      wb_data  <= accept_data;
    end else if (drain) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= wb_valid;
    end
  end

endmodule

// File: rtl/hack_screen_arbiter.sv
// Single-port screen RAM arbiter: VGA scanout first, then posted CPU writes, then CPU reads.
// Optional starvation guard enabled by defining SCREEN_ARB_STARVE_GUARD_EN.
module hack_screen_arbiter
  import hack_screen_pkg::*;
#(
  parameter int MAX_VGA_RUN = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  hack_screen_arbiter_if.slave bus
);

  slot_t slot_s;
  slot_t tag_r;
  logic  wb_valid_s;
  addr_t wb_addr_s;
  word_t wb_data_s;
  logic  rd_pend_s;
  logic  cpu_work_s;
  logic  wr_accept_s;
  logic  guard_force_s;

  // Reads wait behind a buffered write, which gives read-after-write ordering for free.
  assign rd_pend_s   = bus.cpu_req & ~bus.cpu_we & ~wb_valid_s;
  assign cpu_work_s  = wb_valid_s | (bus.cpu_req & ~bus.cpu_we);
  assign wr_accept_s = rst_n & bus.cpu_req & bus.cpu_we & ~wb_valid_s;

`ifdef SCREEN_ARB_STARVE_GUARD_EN
  localparam int RUN_W = $clog2(MAX_VGA_RUN + 1);

  logic [RUN_W-1:0] run_cnt_r;

  assign guard_force_s = cpu_work_s & (run_cnt_r == RUN_W'(MAX_VGA_RUN));

  // Count VGA slots taken while the CPU side is waiting; any other slot restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_r <= {RUN_W{1'b0}};
    end else if ((slot_s == VGA) && cpu_work_s) begin
      run_cnt_r <= run_cnt_r + RUN_W'(1);
    end else begin
      run_cnt_r <= {RUN_W{1'b0}};
    end
  end
`else
  localparam int unused_max_vga_run = MAX_VGA_RUN;

  assign guard_force_s = 1'b0;
`endif

  // Slot selection for this cycle.
  always_comb begin
    slot_s = NONE;
    if (!rst_n) begin
      slot_s = NONE;
    end else if (bus.vga_req && !guard_force_s) begin
      slot_s = VGA;
    end else if (wb_valid_s) begin
      slot_s = WB;
    end else if (rd_pend_s) begin
      slot_s = CPURD;
    end else begin
      slot_s = NONE;
    end
  end

  // Grants and memory strobes follow the current decision; idle address/data are forced to 0.
  always_comb begin
    bus.vga_gnt   = 1'b0;
    bus.cpu_gnt   = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {SCREEN_AW{1'b0}};
    bus.mem_wdata = {WORD_W{1'b0}};
    bus.vga_gnt   = (slot_s == VGA);
    bus.cpu_gnt   = wr_accept_s | (slot_s == CPURD);
    bus.mem_en    = (slot_s != NONE);
    bus.mem_we    = (slot_s == WB);
    case (slot_s)
      VGA:     bus.mem_addr = bus.vga_addr;
      CPURD:   bus.mem_addr = bus.cpu_addr;
      WB: begin
        bus.mem_addr  = wb_addr_s;
        bus.mem_wdata = wb_data_s;
      end
      default: bus.mem_addr = {SCREEN_AW{1'b0}};
    endcase
  end

  // Return tag; clearing it on reset drops the return pulse of an in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_r <= NONE;
    end else begin
      tag_r <= slot_s;
    end
  end

  assign bus.vga_valid  = (tag_r == VGA);
  assign bus.cpu_rvalid = (tag_r == CPURD);
  assign bus.vga_rdata  = rst_n ? bus.mem_rdata : {WORD_W{1'b0}};
  assign bus.cpu_rdata  = rst_n ? bus.mem_rdata : {WORD_W{1'b0}};

  screen_wbuf u_wbuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .accept      (wr_accept_s),
    .accept_addr (bus.cpu_addr),
    .accept_data (bus.cpu_wdata),
    .drain       (slot_is_cpu(slot_s) && (slot_s == WB)),
    .wb_valid    (wb_valid_s),
    .wb_addr     (wb_addr_s),
    .wb_data     (wb_data_s)
  );

endmodule

// File: tb/tb_hack_screen_arbiter.sv
// Scoreboard bench for hack_screen_arbiter with a synchronous screen RAM model.
module tb_hack_screen_arbiter;
  import hack_screen_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  hack_screen_arbiter_if bus();

  hack_screen_arbiter #(.MAX_VGA_RUN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Screen RAM model: unwritten words read back as 16'hC000 | address.
  logic [15:0] mem [0:8191];
  bit          wr_mask [0:8191];
  logic [15:0] mem_q = 16'h0000;

  assign bus.mem_rdata = mem_q;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr]     <= bus.mem_wdata;
        wr_mask[bus.mem_addr] <= 1'b1;
      end
      mem_q <= wr_mask[bus.mem_addr] ? mem[bus.mem_addr] : (16'hC000 | {3'b000, bus.mem_addr});
    end
  end

  logic [15:0] vga_q [$];
  logic [15:0] rd_q  [$];
  logic [28:0] wr_q  [$];
  logic [28:0] wr_e;
  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Monitor: every returned datum or memory write must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.vga_valid) begin
        if (vga_q.size() == 0) check("vga_valid_unexpected", 32'(bus.vga_valid), 32'h0);
        else check("vga_rdata", 32'(bus.vga_rdata), 32'(vga_q.pop_front()));
      end
      if (bus.cpu_rvalid) begin
        if (rd_q.size() == 0) check("cpu_rvalid_unexpected", 32'(bus.cpu_rvalid), 32'h0);
        else check("cpu_rdata", 32'(bus.cpu_rdata), 32'(rd_q.pop_front()));
      end
      if (bus.mem_en && bus.mem_we) begin
        if (wr_q.size() == 0) check("mem_we_unexpected", 32'(bus.mem_we), 32'h0);
        else begin
          wr_e = wr_q.pop_front();
          check("mem_write", 32'({bus.mem_addr, bus.mem_wdata}), 32'(wr_e));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic vga_set(input logic req, input logic [12:0] a);
    bus.vga_req  = req;
    bus.vga_addr = a;
  endtask

  task automatic cpu_set(input logic req, input logic we, input logic [12:0] a, input logic [15:0] d);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_vga_gnt"},    32'(bus.vga_gnt),    32'h0);
    check({tag, "_cpu_gnt"},    32'(bus.cpu_gnt),    32'h0);
    check({tag, "_vga_valid"},  32'(bus.vga_valid),  32'h0);
    check({tag, "_cpu_rvalid"}, 32'(bus.cpu_rvalid), 32'h0);
    check({tag, "_vga_rdata"},  32'(bus.vga_rdata),  32'h0);
    check({tag, "_cpu_rdata"},  32'(bus.cpu_rdata),  32'h0);
    check({tag, "_mem_en"},     32'(bus.mem_en),     32'h0);
    check({tag, "_mem_we"},     32'(bus.mem_we),     32'h0);
    check({tag, "_mem_addr"},   32'(bus.mem_addr),   32'h0);
    check({tag, "_mem_wdata"},  32'(bus.mem_wdata),  32'h0);
  endtask

  logic exp_cpu;

  initial begin
    rst_n = 1'b0;
    vga_set(1'b1, 13'h0005);
    cpu_set(1'b1, 1'b1, 13'h0300, 16'h7777);
    step();
    mid();
    chk_reset_outputs("por");
    step();
    rst_n = 1'b1;
    vga_set(1'b0, 13'h0000);
    cpu_set(1'b0, 1'b0, 13'h0000, 16'h0000);
    step();

    // Reset mid-activity: buffered write and in-flight VGA read are both dropped.
    vga_set(1'b1, 13'h0020);
    cpu_set(1'b1, 1'b1, 13'h0300, 16'h7777);
    vga_q.push_back(16'hC020);
    mid();
    check("t1_vga_gnt", 32'(bus.vga_gnt), 32'h1);
    check("t1_cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
    step();
    vga_set(1'b1, 13'h0021);
    cpu_set(1'b0, 1'b0, 13'h0000, 16'h0000);
    mid();
    check("t1_vga_gnt2", 32'(bus.vga_gnt), 32'h1);
    check("t1_wb_held", 32'(bus.mem_we), 32'h0);
    step();
    rst_n = 1'b0;
    cpu_set(1'b1, 1'b0, 13'h0022, 16'h0000);
    mid();
    chk_reset_outputs("mid");
    step();
    rst_n = 1'b1;
    vga_set(1'b0, 13'h0000);
    cpu_set(1'b0, 1'b0, 13'h0000, 16'h0000);
    mid();
    check("t1_no_vga_valid", 32'(bus.vga_valid), 32'h0);
    check("t1_no_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    check("t1_wb_discarded", 32'(bus.mem_en), 32'h0);
    step();
    cpu_set(1'b1, 1'b1, 13'h0301, 16'h1111);
    wr_q.push_back({13'h0301, 16'h1111});
    mid();
    check("t1_next_wr_gnt", 32'(bus.cpu_gnt), 32'h1);
    step();
    cpu_set(1'b0, 1'b0, 13'h0000, 16'h0000);
    mid();
    check("t1_next_wr_drain", 32'(bus.mem_we), 32'h1);
    step();
    check("t1_old_write_lost", 32'(wr_mask[13'h0300]), 32'h0);

    // VGA stream 0..7 with a posted write at cycle 2 and a stalled second write.
    for (int i = 0; i < 8; i++) begin
      vga_set(1'b1, 13'(i));
      vga_q.push_back(16'hC000 | 16'(i));
      if (i == 2) begin
        cpu_set(1'b1, 1'b1, 13'h0100, 16'h1234);
        wr_q.push_back({13'h0100, 16'h1234});
      end else if (i > 2) begin
        cpu_set(1'b1, 1'b1, 13'h0101, 16'h5678);
      end
      mid();
      check("t2_vga_gnt", 32'(bus.vga_gnt), 32'h1);
      check("t2_mem_addr", 32'(bus.mem_addr), 32'(i));
      check("t2_cpu_gnt", 32'(bus.cpu_gnt), (i == 2) ? 32'h1 : 32'h0);
      check("t2_no_write", 32'(bus.mem_we), 32'h0);
      step();
    end
    vga_set(1'b0, 13'h0000);
    mid();
    check("t2_drain_we", 32'(bus.mem_we), 32'h1);
    check("t2_drain_addr", 32'(bus.mem_addr), 32'h0100);
    check("t2_second_stall", 32'(bus.cpu_gnt), 32'h0);
    step();
    wr_q.push_back({13'h0101, 16'h5678});
    mid();
    check("t2_second_gnt", 32'(bus.cpu_gnt), 32'h1);
    check("t2_second_no_slot", 32'(bus.mem_en), 32'h0);
    step();
    cpu_set(1'b0, 1'b0, 13'h0000, 16'h0000);
    mid();
    check("t2_second_drain", 32'(bus.mem_we), 32'h1);
    step();

    // Read-after-write: the read waits for the drain and sees the new data.
    cpu_set(1'b1, 1'b1, 13'h0200, 16'hBEEF);
    wr_q.push_back({13'h0200, 16'hBEEF});
    mid();
    check("t3_wr_gnt", 32'(bus.cpu_gnt), 32'h1);
    step();
    cpu_set(1'b1, 1'b0, 13'h0200, 16'h0000);
    mid();
    check("t3_rd_wait", 32'(bus.cpu_gnt), 32'h0);
    check("t3_drain_first", 32'(bus.mem_we), 32'h1);
    step();
    rd_q.push_back(16'hBEEF);
    mid();
    check("t3_rd_gnt", 32'(bus.cpu_gnt), 32'h1);
    check("t3_rd_en", 32'(bus.mem_en), 32'h1);
    check("t3_rd_we", 32'(bus.mem_we), 32'h0);
    check("t3_rd_addr", 32'(bus.mem_addr), 32'h0200);
    step();
    cpu_set(1'b0, 1'b0, 13'h0000, 16'h0000);
    mid();
    check("t3_rvalid", 32'(bus.cpu_rvalid), 32'h1);
    step();
    mid();
    check("t3_rvalid_one_cycle", 32'(bus.cpu_rvalid), 32'h0);
    step();

    // Idle CPU read at the top address.
    cpu_set(1'b1, 1'b0, 13'h1FFF, 16'h0000);
    rd_q.push_back(16'hDFFF);
    mid();
    check("t4_mem_en", 32'(bus.mem_en), 32'h1);
    check("t4_cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
    check("t4_mem_addr", 32'(bus.mem_addr), 32'h1FFF);
    check("t4_vga_gnt", 32'(bus.vga_gnt), 32'h0);
    step();
    cpu_set(1'b0, 1'b0, 13'h0000, 16'h0000);
    mid();
    check("t4_rvalid", 32'(bus.cpu_rvalid), 32'h1);
    check("t4_no_vga_valid", 32'(bus.vga_valid), 32'h0);
    step();

    // Continuous scanout with a pending CPU read.
    cpu_set(1'b1, 1'b0, 13'h0040, 16'h0000);
    for (int k = 0; k < 15; k++) begin
      vga_set(1'b1, 13'h0050 + 13'(k));
`ifdef SCREEN_ARB_STARVE_GUARD_EN
      exp_cpu = ((k % 5) == 4);
`else
      exp_cpu = 1'b0;
`endif
      if (exp_cpu) rd_q.push_back(16'hC040);
      else vga_q.push_back(16'hC050 + 16'(k));
      mid();
      check("t5_vga_gnt", 32'(bus.vga_gnt), 32'(!exp_cpu));
      check("t5_cpu_gnt", 32'(bus.cpu_gnt), 32'(exp_cpu));
      step();
    end
    vga_set(1'b0, 13'h0000);
    rd_q.push_back(16'hC040);
    mid();
    check("t5_idle_cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
    step();
    cpu_set(1'b0, 1'b0, 13'h0000, 16'h0000);
    repeat (3) step();

    check("end_vga_q_empty", 32'(vga_q.size()), 32'h0);
    check("end_rd_q_empty", 32'(rd_q.size()), 32'h0);
    check("end_wr_q_empty", 32'(wr_q.size()), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
